// File: rtl/uart_pkg.sv
// Shared types and helpers for the FPGA<->host UART link.
//   parity_e    : framing parity mode (none / odd / even)
//   rx_state_e  : receive engine states
//   tx_state_e  : transmit engine states
//   IDLE_LVL    : level of an idle serial line
//   parity_of() : parity bit for up to 9 payload bits (zero-extend narrower payloads)
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam logic IDLE_LVL = 1'b1;

    // Even parity is the XOR of the payload; odd parity is its inverse.
    function automatic logic parity_of(input logic [8:0] data, input parity_e mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst  : clock, asynchronous active-low reset
//   wr_en     : push wr_data (dropped when full unless a pop happens in the same cycle)
//   rd_en     : pop the head (ignored when empty)
//   rd_data   : current head, forced to zero while empty
//   empty/full: occupancy flags
//   level     : number of stored entries, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and level define validity, so the
    // array stays a plain RAM and its stale contents are never observable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fpga_pc_uart_fifo_interface.sv
// FPGA<->host UART link with FIFO buffering in both directions.
//   clk, rst        : single clock; asynchronous active-low reset, released synchronously inside
//   rx_d_in         : serial from host (idle high, asynchronous)
//   tx_d_out        : serial to host (idle high, registered)
//   tx_wr_en/data   : push a byte into the TX FIFO; tx_full / tx_level report occupancy
//   tx_busy         : a frame is on the line; tx_done pulses once per completed frame
//   rx_rd_en        : pop the RX FIFO; rx_rd_data is the head (zero while rx_empty)
//   rx_level        : RX FIFO occupancy
//   rx_frame_err    : sticky, stop bit sampled low
//   rx_parity_err   : sticky, parity mismatch
//   rx_overflow     : sticky, received byte lost to a full RX FIFO
//   err_clear       : clears the sticky flags (a same-cycle set wins)
module fpga_pc_uart_fifo_interface
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_d_in,
    output logic                        tx_d_out,
    input  logic                        tx_wr_en,
    input  logic [DATA_BITS-1:0]        tx_wr_data,
    output logic                        tx_full,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic                        tx_busy,
    output logic                        tx_done,
    input  logic                        rx_rd_en,
    output logic [DATA_BITS-1:0]        rx_rd_data,
    output logic                        rx_empty,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        rx_frame_err,
    output logic                        rx_parity_err,
    output logic                        rx_overflow,
    input  logic                        err_clear
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0]  LAST_DATA  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST_STOP  = IDX_W'(STOP_BITS - 1);
    localparam parity_e           PAR_MODE   = parity_e'(PARITY[1:0]);
    localparam bit                HAS_PARITY = (PARITY != 0);

    // Reset asserts immediately but is released on a clock edge.
    logic rst_meta, rst_n_int;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rst_meta, rst_n_int} <= 2'b00;
        else      {rst_meta, rst_n_int} <= {1'b1, rst_meta};
    end

    // ---------------------------------------------------------------- receive
    logic rx_meta, rx_sync;
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rx_meta <= IDLE_LVL;
            rx_sync <= IDLE_LVL;
        end else begin
            rx_meta <= rx_d_in;
            rx_sync <= rx_meta;
        end
    end

    rx_state_e            rx_state, rx_state_nxt;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_ok, rx_push, rx_full;
    logic                 rx_take_bit, rx_take_par, rx_stop_bad, rx_frame_good;
    logic                 rx_half, rx_bit_end;

    assign rx_half    = (rx_cnt == CNT_HALF);
    assign rx_bit_end = (rx_cnt == CNT_LAST);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        rx_state_nxt  = rx_state;
        rx_take_bit   = 1'b0;
        rx_take_par   = 1'b0;
        rx_stop_bad   = 1'b0;
        rx_frame_good = 1'b0;
        case (rx_state)
            RX_IDLE:   if (rx_sync != IDLE_LVL) rx_state_nxt = RX_START;
            // Mid-start re-check rejects glitches shorter than half a bit.
            RX_START:  if (rx_half) rx_state_nxt = (rx_sync == IDLE_LVL) ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_bit_end) begin
                           rx_take_bit = 1'b1;
                           if (rx_idx == LAST_DATA) rx_state_nxt = HAS_PARITY ? RX_PARITY : RX_STOP;
                       end
            RX_PARITY: if (rx_bit_end) begin
                           rx_take_par  = 1'b1;
                           rx_state_nxt = RX_STOP;
                       end
            RX_STOP:   if (rx_bit_end) begin
                           if (rx_sync != IDLE_LVL) begin
                               rx_stop_bad  = 1'b1;
                               rx_state_nxt = RX_WAIT_HIGH;
                           end else if (rx_idx == LAST_STOP) begin
                               rx_frame_good = 1'b1;
                               rx_state_nxt  = RX_IDLE;
                           end
                       end
            RX_WAIT_HIGH: if (rx_sync == IDLE_LVL) rx_state_nxt = RX_IDLE;
            default:   rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_par_ok     <= 1'b1;
            rx_push       <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overflow   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_push  <= rx_frame_good && rx_par_ok;
            if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH ||
                rx_state_nxt != rx_state || rx_bit_end)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state_nxt != rx_state) rx_idx <= '0;
            else if (rx_bit_end)          rx_idx <= rx_idx + 1'b1;
            if (rx_take_bit) rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_state == RX_IDLE) rx_par_ok <= 1'b1;
            else if (rx_take_par)    rx_par_ok <= (rx_sync == parity_of(9'(rx_shift), PAR_MODE));
            // A stop error ends the frame before the parity verdict, so it takes precedence.
            rx_frame_err  <= rx_stop_bad | (rx_frame_err & ~err_clear);
            rx_parity_err <= (rx_frame_good & ~rx_par_ok) | (rx_parity_err & ~err_clear);
            rx_overflow   <= (rx_push & rx_full & ~rx_rd_en) | (rx_overflow & ~err_clear);
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst_n_int),
        .wr_en   (rx_push),
        .wr_data (rx_shift),
        .rd_en   (rx_rd_en),
        .rd_data (rx_rd_data),
        .empty   (rx_empty),
        .full    (rx_full),
        .level   (rx_level)
    );

    // --------------------------------------------------------------- transmit
    tx_state_e            tx_state, tx_state_nxt;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx, tx_idx_nxt;
    logic [DATA_BITS-1:0] tx_data, tx_rd_data;
    logic                 tx_empty, tx_pop, tx_done_nxt, tx_line_nxt, tx_bit_end;

    assign tx_bit_end = (tx_cnt == CNT_LAST);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        tx_done_nxt  = 1'b0;
        case (tx_state)
            TX_IDLE:   if (!tx_empty) begin
                           tx_pop       = 1'b1;
                           tx_state_nxt = TX_START;
                       end
            TX_START:  if (tx_bit_end) tx_state_nxt = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_idx == LAST_DATA)
                           tx_state_nxt = HAS_PARITY ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_state_nxt = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_idx == LAST_STOP) begin
                           tx_done_nxt = 1'b1;
                           // Chain straight into the next start bit when more data is queued.
                           if (!tx_empty) begin
                               tx_pop       = 1'b1;
                               tx_state_nxt = TX_START;
                           end else begin
                               tx_state_nxt = TX_IDLE;
                           end
                       end
            default:   tx_state_nxt = TX_IDLE;
        endcase

        if (tx_state_nxt != tx_state) tx_idx_nxt = '0;
        else if (tx_bit_end)          tx_idx_nxt = tx_idx + 1'b1;
        else                          tx_idx_nxt = tx_idx;

        // The line level is registered from the next state so tx_d_out never glitches.
        case (tx_state_nxt)
            TX_START:  tx_line_nxt = 1'b0;
            TX_DATA:   tx_line_nxt = tx_data[tx_idx_nxt];
            TX_PARITY: tx_line_nxt = parity_of(9'(tx_data), PAR_MODE);
            default:   tx_line_nxt = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
            tx_d_out <= IDLE_LVL;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_cnt   <= (tx_state == TX_IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
            if (tx_pop) tx_data <= tx_rd_data;
            tx_d_out <= tx_line_nxt;
            tx_busy  <= (tx_state_nxt != TX_IDLE);
            tx_done  <= tx_done_nxt;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst_n_int),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (tx_pop),
        .rd_data (tx_rd_data),
        .empty   (tx_empty),
        .full    (tx_full),
        .level   (tx_level)
    );

endmodule

// File: tb/tb_fpga_pc_uart_fifo_interface.sv
// Directed bench: an even-parity instance (TX and RX tests) and an odd-parity instance
// (parity error and glitch rejection), both at 4 clocks per bit with 16-entry FIFOs.
module tb_fpga_pc_uart_fifo_interface;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // even-parity instance
    logic       rx_e, tx_e, tx_wr_en_e, tx_full_e, tx_busy_e, tx_done_e;
    logic [7:0] tx_wr_data_e, rx_rd_data_e;
    logic [4:0] tx_level_e, rx_level_e;
    logic       rx_rd_en_e, rx_empty_e, ferr_e, perr_e, ovf_e, clr_e;

    // odd-parity instance
    logic       rx_o, tx_o, tx_wr_en_o, tx_full_o, tx_busy_o, tx_done_o;
    logic [7:0] tx_wr_data_o, rx_rd_data_o;
    logic [4:0] tx_level_o, rx_level_o;
    logic       rx_rd_en_o, rx_empty_o, ferr_o, perr_o, ovf_o, clr_o;

    fpga_pc_uart_fifo_interface #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_even (
        .clk(clk), .rst(rst), .rx_d_in(rx_e), .tx_d_out(tx_e),
        .tx_wr_en(tx_wr_en_e), .tx_wr_data(tx_wr_data_e), .tx_full(tx_full_e),
        .tx_level(tx_level_e), .tx_busy(tx_busy_e), .tx_done(tx_done_e),
        .rx_rd_en(rx_rd_en_e), .rx_rd_data(rx_rd_data_e), .rx_empty(rx_empty_e),
        .rx_level(rx_level_e), .rx_frame_err(ferr_e), .rx_parity_err(perr_e),
        .rx_overflow(ovf_e), .err_clear(clr_e)
    );

    fpga_pc_uart_fifo_interface #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_odd (
        .clk(clk), .rst(rst), .rx_d_in(rx_o), .tx_d_out(tx_o),
        .tx_wr_en(tx_wr_en_o), .tx_wr_data(tx_wr_data_o), .tx_full(tx_full_o),
        .tx_level(tx_level_o), .tx_busy(tx_busy_o), .tx_done(tx_done_o),
        .rx_rd_en(rx_rd_en_o), .rx_rd_data(rx_rd_data_o), .rx_empty(rx_empty_o),
        .rx_level(rx_level_o), .rx_frame_err(ferr_o), .rx_parity_err(perr_o),
        .rx_overflow(ovf_o), .err_clear(clr_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (tx_done_e === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame (start, 8 data LSB first, parity, one stop) at 4 clocks per bit.
    // Called at a falling edge; returns at a falling edge with the line idle.
    task automatic send_frame(input bit to_odd, input logic [7:0] d,
                              input logic par, input logic stop);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            if (to_odd) rx_o = f[k]; else rx_e = f[k];
            repeat (4) @(negedge clk);
        end
        if (to_odd) rx_o = 1'b1; else rx_e = 1'b1;
    endtask

    // Samples the even instance's TX line in the second cycle of each of n bits.
    task automatic capture_tx(input int n, output logic [63:0] bits, output int busy_lows);
        bits      = '0;
        busy_lows = 0;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            bits[k] = tx_e;
            if (tx_busy_e !== 1'b1) busy_lows++;
            if (k != n - 1) repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] bits;
        logic [63:0] exp_bits;
        int          busy_lows;
        int          done0;
        int          line_lows;

        rst = 1'b0;
        rx_e = 1'b1; tx_wr_en_e = 1'b0; tx_wr_data_e = '0; rx_rd_en_e = 1'b0; clr_e = 1'b0;
        rx_o = 1'b1; tx_wr_en_o = 1'b0; tx_wr_data_o = '0; rx_rd_en_o = 1'b0; clr_o = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset state
        check("rst_tx_line",  tx_e,         1);
        check("rst_tx_busy",  tx_busy_e,    0);
        check("rst_tx_done",  tx_done_e,    0);
        check("rst_tx_full",  tx_full_e,    0);
        check("rst_tx_level", tx_level_e,   0);
        check("rst_rx_empty", rx_empty_e,   1);
        check("rst_rx_level", rx_level_e,   0);
        check("rst_rx_data",  rx_rd_data_e, 0);
        check("rst_flags",    {ferr_e, perr_e, ovf_e}, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // ---- 1: single even-parity frame of 0xA5
        done0 = done_cnt;
        tx_wr_data_e = 8'hA5; tx_wr_en_e = 1'b1;
        @(posedge clk); #1 tx_wr_en_e = 1'b0;
        @(negedge clk);
        check("t1_line_c1",  tx_e,       1);
        check("t1_level_c1", tx_level_e, 1);
        @(negedge clk);
        check("t1_line_c2",  tx_e,       0);
        check("t1_busy_c2",  tx_busy_e,  1);
        check("t1_level_c2", tx_level_e, 0);
        capture_tx(11, bits, busy_lows);
        exp_bits = 64'({1'b1, 1'b0, 8'hA5, 1'b0});
        check("t1_frame", bits, exp_bits);
        repeat (8) @(negedge clk);
        check("t1_done_pulses", done_cnt - done0, 1);
        check("t1_busy_end",    tx_busy_e, 0);
        check("t1_line_end",    tx_e,      1);

        // ---- 2: burst of three bytes, no idle gap between frames
        done0 = done_cnt;
        tx_wr_en_e = 1'b1; tx_wr_data_e = 8'h11;
        @(negedge clk); tx_wr_data_e = 8'h22;
        @(negedge clk); tx_wr_data_e = 8'h33;
        check("t2_line_start", tx_e, 0);
        @(posedge clk); #1 tx_wr_en_e = 1'b0;
        // first byte left the FIFO as soon as it arrived
        check("t2_level_peak", tx_level_e, 2);
        capture_tx(33, bits, busy_lows);
        exp_bits = 64'({1'b1, 1'b0, 8'h33, 1'b0,
                        1'b1, 1'b0, 8'h22, 1'b0,
                        1'b1, 1'b0, 8'h11, 1'b0});
        check("t2_frames",     bits,      exp_bits);
        check("t2_busy_gaps",  busy_lows, 0);
        check("t2_level_mid",  tx_level_e, 0);
        repeat (8) @(negedge clk);
        check("t2_done_pulses", done_cnt - done0, 3);
        check("t2_busy_end",    tx_busy_e, 0);

        // ---- 3: RX overflow with 20 back-to-back frames
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            d = 8'(i);
            send_frame(1'b0, d, ^d, 1'b1);
        end
        repeat (6) @(negedge clk);
        check("t3_level_full", rx_level_e, 16);
        check("t3_overflow",   ovf_e,      1);
        check("t3_no_ferr",    ferr_e,     0);
        check("t3_no_perr",    perr_e,     0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_rd%0d", i), rx_rd_data_e, 64'(i));
            rx_rd_en_e = 1'b1;
            @(posedge clk); #1 rx_rd_en_e = 1'b0;
            @(negedge clk);
        end
        check("t3_empty", rx_empty_e,   1);
        check("t3_level", rx_level_e,   0);
        check("t3_zero",  rx_rd_data_e, 0);

        // ---- 4: framing error, clear, then recovery
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("t4_ferr",  ferr_e,     1);
        check("t4_empty", rx_empty_e, 1);
        check("t4_perr",  perr_e,     0);
        clr_e = 1'b1;
        @(posedge clk); #1 clr_e = 1'b0;
        @(negedge clk);
        check("t4_ferr_clr", ferr_e, 0);
        check("t4_ovf_clr",  ovf_e,  0);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("t4_good_data",  rx_rd_data_e, 8'h5A);
        check("t4_good_level", rx_level_e,   1);
        rx_rd_en_e = 1'b1;
        @(posedge clk); #1 rx_rd_en_e = 1'b0;

        // ---- 5: odd parity, wrong parity bit, glitch, then a correct frame
        @(negedge clk);
        send_frame(1'b1, 8'h01, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        check("t5_perr",  perr_o,     1);
        check("t5_empty", rx_empty_o, 1);
        check("t5_ferr",  ferr_o,     0);
        clr_o = 1'b1;
        @(posedge clk); #1 clr_o = 1'b0;
        @(negedge clk);
        check("t5_perr_clr", perr_o, 0);
        rx_o = 1'b0;
        @(negedge clk); rx_o = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_glitch_empty", rx_empty_o,       1);
        check("t5_glitch_flags", {ferr_o, perr_o}, 0);
        send_frame(1'b1, 8'h01, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("t5_good_data", rx_rd_data_o, 8'h01);
        check("t5_good_perr", perr_o,       0);

        // ---- 6: reset in the middle of a frame
        tx_wr_data_e = 8'hFF; tx_wr_en_e = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 tx_wr_en_e = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_busy_pre",  tx_busy_e,  1);
        check("t6_level_pre", tx_level_e, 1);
        rst = 1'b0;
        #1;
        check("t6_line",  tx_e,       1);
        check("t6_busy",  tx_busy_e,  0);
        check("t6_level", tx_level_e, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        line_lows = 0;
        busy_lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_e !== 1'b1)      line_lows++;
            if (tx_busy_e !== 1'b0) busy_lows++;
        end
        check("t6_line_idle", line_lows, 0);
        check("t6_busy_idle", busy_lows, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
